gpio_bridge: RTL and testbench
==============================

GPIO_BRIDGE -- requirements
Module: gpio_bridge

Interface
REQ-001 Parameter NUM_DIP, default 2, number of 32-bit DIP banks; legal range 1..4.
REQ-002 Parameter KEY_W, default 8, number of push keys; legal range 1..32.
REQ-003 Parameter LED_W, default 32, number of LEDs; legal range 1..32.
REQ-004 Parameter DEB_CYC, default 16, debounce stability window in clk cycles; legal range 2..65535.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-007 byteEn  input  4  write byte strobes; any bit set means a write; all zero means no write.
REQ-008 Addr  input  3  word index, bus address bits [4:2].
REQ-009 WD  input  32  write data.
REQ-010 dips  input  32*NUM_DIP  raw DIP switches, active-low; bank b occupies bits [32b+31:32b].
REQ-011 key  input  KEY_W  raw push keys, active-low, asynchronous to clk.
REQ-012 RD  output  32  read data for Addr.
REQ-013 LED  output  LED_W  LED drive, active-low.
REQ-014 irq  output  1  level interrupt request.

Function
REQ-015 Address map: words 0..NUM_DIP-1 DIP bank; word 4 KEY; word 5 LED; word 6 IRQ_EN; word 7 IRQ_PEND. All other words read 0. Writes to them are ignored.
REQ-016 RD shall be combinational from registered state. Read latency is 0 cycles relative to Addr.
REQ-017 DIP bank b shall pass through a 2-flop synchronizer, then be stored inverted. RD = ~dips bank b, 3 cycles after an input change.
REQ-018 Each key bit shall pass through a 2-flop synchronizer and be inverted, giving sync_k (1 = pressed).
REQ-019 Each key shall have a debounce counter and a debounced bit deb_k. While sync_k == deb_k the counter holds 0. While they differ the counter increments. In the cycle the counter reaches DEB_CYC-1, deb_k <= sync_k and the counter clears.
REQ-020 A glitch shorter than DEB_CYC cycles shall not change deb_k, because the counter returns to 0 when sync_k matches deb_k again.
REQ-021 Word 4 RD = zero-extended deb[KEY_W-1:0]; this word is read-only.
REQ-022 Word 5 LED register: each byte lane i with byteEn[i] set takes WD lane i; other lanes hold. Bits at LED_W and above read 0.
REQ-023 LED output = ~LED_reg[LED_W-1:0].
REQ-024 Word 6 IRQ_EN: byte-enabled write, same lane rule as REQ-022. Only bits [KEY_W-1:0] are stored; the rest read 0.
REQ-025 Word 7 IRQ_PEND: pend_k sets in the cycle deb_k goes 0->1 (press edge). Release edges do not set it.
REQ-026 Writing 1 to pend_k in an enabled byte lane clears that bit. Writing 0 has no effect (W1C).
REQ-027 If a press edge and a W1C clear hit the same bit in the same cycle, the set wins and pend_k = 1.
REQ-028 irq = |(pend & en), combinational from registers.
REQ-029 Pending bits shall set regardless of IRQ_EN. Enabling a bit that is already pending asserts irq in the next cycle.

Reset
REQ-030 While reset == 0 at a rising edge, all of the following clear: synchronizers, DIP registers, deb, debounce counters, LED_reg, IRQ_EN and IRQ_PEND.
REQ-031 After reset: RD = 0 for every Addr, LED = all ones (LEDs off), irq = 0.
REQ-032 Reset asserted mid-debounce shall discard the counter. A key held during and after reset needs a full DEB_CYC window after release of reset to register.
REQ-033 The first press edge after reset is detected from deb = 0.

Verification (DEB_CYC=4, KEY_W=8, NUM_DIP=2, LED_W=32)
REQ-034 Reset, then dips = {32'hFFFF0000, 32'h0F0F0F0F}, Addr = 0 and 1 after 3 cycles -> RD = 32'hF0F0F0F0, then 32'h0000FFFF.
REQ-035 LED write WD = 32'hA5A5A5A5 with byteEn = 4'b1111, then WD = 32'h000000FF with byteEn = 4'b0001 -> Addr 5 reads 32'hA5A5A5FF and LED = 32'h5A5A5A00.
REQ-036 key[3] low for 2 cycles, then high -> deb stays 0, word 7 reads 0, irq = 0.
REQ-037 key[3] held low for 10 or more cycles with IRQ_EN = 32'h08 -> word 4 reads 32'h08, word 7 reads 32'h08, irq = 1. Write 32'h08 to word 7 -> pend = 0, irq = 0.
REQ-038 Press edge on key[0] in the same cycle as a W1C of bit 0 -> pend[0] = 1. IRQ_EN = 0 keeps irq = 0. Then write IRQ_EN = 1 -> irq = 1 in the next cycle.
REQ-039 Assert reset while LED_reg = 32'hFFFFFFFF and pend = 8'hFF -> next cycle LED = 32'hFFFFFFFF (off), all reads 0, irq = 0.

Source files
------------

// File: rtl/gpio_bridge.sv
// GPIO bridge: DIP banks, debounced keys with press interrupts,
// byte-writable LED register, all on a small word-addressed bus.
module gpio_bridge #(
    parameter int NUM_DIP = 2,
    parameter int KEY_W   = 8,
    parameter int LED_W   = 32,
    parameter int DEB_CYC = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             byteEn,
    input  logic [2:0]             Addr,
    input  logic [31:0]            WD,
    input  logic [32*NUM_DIP-1:0]  dips,
    input  logic [KEY_W-1:0]       key,
    output logic [31:0]            RD,
    output logic [LED_W-1:0]       LED,
    output logic                   irq
);

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);

    logic [32*NUM_DIP-1:0] r_dip_s1;
    logic [32*NUM_DIP-1:0] r_dip_s2;
    logic [32*NUM_DIP-1:0] r_dip;
    logic [KEY_W-1:0]      r_key_s1;
    logic [KEY_W-1:0]      r_key_s2;
    logic [KEY_W-1:0]      r_deb;
    logic [KEY_W-1:0]      r_en;
    logic [KEY_W-1:0]      r_pend;
    logic [15:0]           r_cnt [KEY_W];
    logic [LED_W-1:0]      r_led;

    logic                  w_we;
    logic [31:0]           w_lane;
    logic [LED_W-1:0]      w_led_wr;
    logic [KEY_W-1:0]      w_en_wr;
    logic [KEY_W-1:0]      w_clr;
    logic [KEY_W-1:0]      w_press;
    logic [31:0]           w_rd;

    assign w_we   = |byteEn;
    assign w_lane = {{8{byteEn[3]}}, {8{byteEn[2]}},
                     {8{byteEn[1]}}, {8{byteEn[0]}}};

    assign w_led_wr = (r_led & ~w_lane[LED_W-1:0])
                    | (WD[LED_W-1:0] & w_lane[LED_W-1:0]);
    assign w_en_wr  = (r_en & ~w_lane[KEY_W-1:0])
                    | (WD[KEY_W-1:0] & w_lane[KEY_W-1:0]);
    assign w_clr    = (w_we && Addr == 3'd7)
                    ? (WD[KEY_W-1:0] & w_lane[KEY_W-1:0])
                    : '0;

    // A press edge is the debounced bit flipping from 0 to 1 this cycle
    always_comb begin
        w_press = '0;
        for (int k = 0; k < KEY_W; k++) begin
            w_press[k] = r_key_s2[k] & ~r_deb[k]
                       & (r_cnt[k] == DEB_LAST);
        end
    end

    // Synchronizers hold the inverted (active-high) sense, so reset means released
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dip_s1 <= '0;
            r_dip_s2 <= '0;
            r_dip    <= '0;
            r_key_s1 <= '0;
            r_key_s2 <= '0;
            r_deb    <= '0;
            r_en     <= '0;
            r_pend   <= '0;
            r_led    <= '0;
            for (int k = 0; k < KEY_W; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_dip_s1 <= ~dips;
            r_dip_s2 <= r_dip_s1;
            r_dip    <= r_dip_s2;
            r_key_s1 <= ~key;
            r_key_s2 <= r_key_s1;
            for (int k = 0; k < KEY_W; k++) begin
                if (r_key_s2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == DEB_LAST) begin
                    r_deb[k] <= r_key_s2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + 16'd1;
                end
            end
            if (w_we && Addr == 3'd5) begin
                r_led <= w_led_wr;
            end
            if (w_we && Addr == 3'd6) begin
                r_en <= w_en_wr;
            end
            r_pend <= (r_pend & ~w_clr) | w_press;
        end
    end

    always_comb begin
        w_rd = '0;
        case (Addr)
            3'd4: w_rd[KEY_W-1:0] = r_deb;
            3'd5: w_rd[LED_W-1:0] = r_led;
            3'd6: w_rd[KEY_W-1:0] = r_en;
            3'd7: w_rd[KEY_W-1:0] = r_pend;
            default: begin
                for (int b = 0; b < NUM_DIP; b++) begin
                    if (Addr == 3'(b)) begin
                        w_rd = r_dip[32*b +: 32];
                    end
                end
            end
        endcase
    end

    assign RD  = w_rd;
    assign LED = ~r_led;
    assign irq = |(r_pend & r_en);

endmodule

// File: tb/tb_gpio_bridge.sv
// Bench for gpio_bridge: directed tables and sequences plus randomized
// traffic checked against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_gpio_bridge;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  byteEn;
    logic [2:0]  Addr;
    logic [31:0] WD;
    logic [63:0] dips;
    logic [7:0]  key;
    logic [31:0] RD;
    logic [31:0] LED;
    logic        irq;

    int n_pass = 0;
    int n_total = 0;

    gpio_bridge #(
        .NUM_DIP(2), .KEY_W(8), .LED_W(32), .DEB_CYC(DEB)
    ) dut (
        .clk(clk), .reset(reset), .byteEn(byteEn), .Addr(Addr),
        .WD(WD), .dips(dips), .key(key), .RD(RD), .LED(LED), .irq(irq)
    );

    always #10 clk = ~clk;

    // Behavioural model: delay lines for the synchronizers, run-length
    // counting of disagreement for the debounce, plain register maps.
    logic [63:0] m_dh0 = '0, m_dh1 = '0, m_dip = '0;
    logic [7:0]  m_kh0 = '0, m_kh1 = '0;
    logic [7:0]  m_deb = '0, m_en = '0, m_pend = '0;
    logic [31:0] m_led = '0;
    int          m_run [8] = '{default: 0};

    always @(posedge clk) begin
        logic [7:0] press;
        logic [7:0] clr;
        press = '0;
        clr = '0;
        if (!reset) begin
            m_dh0 = '0; m_dh1 = '0; m_dip = '0;
            m_kh0 = '0; m_kh1 = '0;
            m_deb = '0; m_en = '0; m_pend = '0; m_led = '0;
            for (int k = 0; k < 8; k++) m_run[k] = 0;
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (m_kh1[k] != m_deb[k]) begin
                    m_run[k] += 1;
                    if (m_run[k] == DEB) begin
                        m_deb[k] = m_kh1[k];
                        m_run[k] = 0;
                        press[k] = m_kh1[k];
                    end
                end else begin
                    m_run[k] = 0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    if (Addr == 3'd5) m_led[8*i +: 8] = WD[8*i +: 8];
                    if (Addr == 3'd6 && i == 0) m_en = WD[7:0];
                    if (Addr == 3'd7 && i == 0) clr = WD[7:0];
                end
            end
            m_pend = (m_pend & ~clr) | press;
            m_dip = m_dh1; m_dh1 = m_dh0; m_dh0 = ~dips;
            m_kh1 = m_kh0; m_kh0 = ~key;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [2:0] a);
        case (a)
            3'd0: return m_dip[31:0];
            3'd1: return m_dip[63:32];
            3'd4: return {24'b0, m_deb};
            3'd5: return m_led;
            3'd6: return {24'b0, m_en};
            3'd7: return {24'b0, m_pend};
            default: return 32'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        else
            n_pass++;
    endtask

    task automatic step(input string nm);
        @(posedge clk);
        #1;
        chk({nm, "_rd"}, RD, exp_rd(Addr));
        chk({nm, "_led"}, LED, ~m_led);
        chk({nm, "_irq"}, {31'b0, irq}, {31'b0, |(m_pend & m_en)});
    endtask

    task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp,
                          input string nm);
        Addr = a;
        #1;
        chk(nm, RD, exp);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] be,
                      input logic [31:0] d, input string nm);
        Addr = a; byteEn = be; WD = d;
        step(nm);
        byteEn = 4'b0;
    endtask

    typedef struct {
        logic [3:0]  be;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic [2:0]  ra;
        logic [31:0] rd;
        logic [31:0] led;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{4'hF, 3'd5, 32'hA5A5A5A5, 3'd5, 32'hA5A5A5A5, 32'h5A5A5A5A};
        tbl[1]  = '{4'h1, 3'd5, 32'h000000FF, 3'd5, 32'hA5A5A5FF, 32'h5A5A5A00};
        tbl[2]  = '{4'h6, 3'd5, 32'h12345678, 3'd5, 32'hA53456FF, 32'h5ACBA900};
        tbl[3]  = '{4'h0, 3'd5, 32'hFFFFFFFF, 3'd5, 32'hA53456FF, 32'h5ACBA900};
        tbl[4]  = '{4'hF, 3'd6, 32'hFFFFFFFF, 3'd6, 32'h000000FF, 32'h5ACBA900};
        tbl[5]  = '{4'h2, 3'd6, 32'h00000000, 3'd6, 32'h000000FF, 32'h5ACBA900};
        tbl[6]  = '{4'h1, 3'd6, 32'h00000000, 3'd6, 32'h00000000, 32'h5ACBA900};
        tbl[7]  = '{4'hF, 3'd4, 32'hFFFFFFFF, 3'd4, 32'h00000000, 32'h5ACBA900};
        tbl[8]  = '{4'hF, 3'd2, 32'hFFFFFFFF, 3'd2, 32'h00000000, 32'h5ACBA900};
        tbl[9]  = '{4'hF, 3'd0, 32'h00000000, 3'd0, 32'hF0F0F0F0, 32'h5ACBA900};
        tbl[10] = '{4'hF, 3'd7, 32'hFFFFFFFF, 3'd7, 32'h00000000, 32'h5ACBA900};
        tbl[11] = '{4'hF, 3'd5, 32'hFFFFFFFF, 3'd5, 32'hFFFFFFFF, 32'h00000000};

        reset = 1'b0; byteEn = '0; Addr = '0; WD = '0;
        dips = '1; key = '1;
        repeat (3) step("rst");
        for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, "rst_rd");
        chk("rst_led", LED, 32'hFFFFFFFF);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        // DIP path latency
        reset = 1'b1;
        dips = {32'hFFFF0000, 32'h0F0F0F0F};
        Addr = 3'd0;
        step("dip"); step("dip");
        rd_chk(3'd0, 32'h0, "dip_lat2");
        step("dip");
        rd_chk(3'd0, 32'hF0F0F0F0, "dip_b0");
        rd_chk(3'd1, 32'h0000FFFF, "dip_b1");

        for (int i = 0; i < 12; i++) begin
            wr(tbl[i].wa, tbl[i].be, tbl[i].wd, "tbl_wr");
            rd_chk(tbl[i].ra, tbl[i].rd, $sformatf("tbl%0d_rd", i));
            chk($sformatf("tbl%0d_led", i), LED, tbl[i].led);
        end

        // Short glitch is filtered
        Addr = 3'd0;
        key = 8'hF7;
        step("glitch"); step("glitch");
        key = 8'hFF;
        repeat (8) step("glitch");
        rd_chk(3'd4, 32'h0, "glitch_deb");
        rd_chk(3'd7, 32'h0, "glitch_pend");
        chk("glitch_irq", {31'b0, irq}, 32'h0);

        // Long press with interrupt enabled, then W1C
        wr(3'd6, 4'h1, 32'h08, "en8");
        key = 8'hF7;
        repeat (5) step("press");
        rd_chk(3'd4, 32'h0, "press_edge5");
        step("press");
        rd_chk(3'd4, 32'h08, "press_deb");
        rd_chk(3'd7, 32'h08, "press_pend");
        chk("press_irq", {31'b0, irq}, 32'h1);
        repeat (4) step("hold");
        wr(3'd7, 4'h1, 32'h08, "w1c");
        rd_chk(3'd7, 32'h0, "w1c_pend");
        chk("w1c_irq", {31'b0, irq}, 32'h0);
        key = 8'hFF;
        repeat (8) step("release");
        rd_chk(3'd4, 32'h0, "release_deb");
        rd_chk(3'd7, 32'h0, "release_pend");

        // Press edge collides with W1C: set wins
        wr(3'd6, 4'h1, 32'h00, "en0");
        key = 8'hFE;
        repeat (5) step("coll");
        wr(3'd7, 4'h1, 32'h01, "coll_w1c");
        rd_chk(3'd7, 32'h01, "coll_pend");
        rd_chk(3'd4, 32'h01, "coll_deb");
        chk("coll_irq_off", {31'b0, irq}, 32'h0);
        wr(3'd6, 4'h1, 32'h01, "en1");
        chk("coll_irq_on", {31'b0, irq}, 32'h1);
        wr(3'd7, 4'h1, 32'h01, "clr0");
        rd_chk(3'd7, 32'h0, "clr0_pend");
        key = 8'hFF;
        repeat (8) step("rel0");

        // Reset with LEDs on, all pending, then a key held across reset
        key = 8'h00;
        repeat (8) step("all");
        wr(3'd6, 4'h1, 32'hFF, "enall");
        rd_chk(3'd7, 32'hFF, "all_pend");
        rd_chk(3'd5, 32'hFFFFFFFF, "all_led");
        chk("all_irq", {31'b0, irq}, 32'h1);
        reset = 1'b0;
        step("rst2");
        for (int a = 0; a < 8; a++) rd_chk(3'(a), 32'h0, "rst2_rd");
        chk("rst2_led", LED, 32'hFFFFFFFF);
        chk("rst2_irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        Addr = 3'd4;
        repeat (5) step("held");
        rd_chk(3'd4, 32'h0, "held_edge5");
        step("held");
        rd_chk(3'd4, 32'hFF, "held_deb");
        key = 8'hFF;
        repeat (8) step("held_rel");

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(3) == 0) begin
                byteEn = 4'($urandom_range(15, 1));
            end else begin
                byteEn = 4'b0;
            end
            Addr = 3'($urandom_range(7));
            WD = $urandom;
            if ($urandom_range(19) == 0)
                dips = {$urandom, $urandom};
            if ($urandom_range(3) == 0)
                key[$urandom_range(7)] ^= 1'b1;
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
